multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences one instruction at a time across fetch, decode, execute, memory and writeback.
- Drives every datapath mux and strobe, including the 2-bit ALU operation code consumed by the ALU control decoder.
- Stalls on a shared-memory ready handshake and keeps a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- opcode  input  6  IR[31:26]; sampled in DECODE only.
- mem_ready  input  1  memory completes current read/write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero (beq).
- i_or_d  output  1  0=PC addresses memory, 1=ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  0=ALUOut, 1=MDR to register file.
- reg_dst  output  1  0=rt, 1=rd.
- reg_write  output  1  register file write.
- alu_src_a  output  1  0=PC, 1=A.
- alu_src_b  output  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
- alu_op  output  2  00 add, 01 sub, 10 R-type funct, 11 and.
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- illegal_op  output  1  one-cycle pulse on unknown opcode.
- state  output  4  current state encoding (debug).
- instr_count  output  CNT_W  retired instructions, wraps.

Behaviour:
- Reset: on a clk edge with rst_n=0, state<=FETCH(0) and instr_count<=0. While rst_n=0, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_op) are forced 0 and all mux selects/alu_op are 0. Reset mid-instruction abandons it with no writes.
- Outputs are Moore-style: decoded from state, with the strobes listed below also gated by mem_ready. Unlisted outputs are 0.
- FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write equal mem_ready. Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next state by opcode:
  - 000000 -> EXECUTE(6)
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR(2)
  - 000100 (beq) -> BRANCH(8)
  - 000010 (j) -> JUMP(9)
  - 001000 (addi) or 001100 (andi) -> IMM_EXEC(10)
  - anything else -> FETCH, with illegal_op=1 this cycle.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ(3) for lw, MEM_WRITE(5) for sw. The opcode is latched in DECODE into an internal register; later states never re-read the port.
- MEM_READ(3): mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB(4).
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Retires; goes to FETCH.
- MEM_WRITE(5): mem_write=1, i_or_d=1. Holds until mem_ready, then retires and goes to FETCH.
- EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB(7).
- R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Retires; goes to FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retires; goes to FETCH.
- JUMP(9): pc_write=1, pc_source=10. Retires; goes to FETCH.
- IMM_EXEC(10): alu_src_a=1, alu_src_b=10. alu_op=00 for addi, 11 for andi. Goes to IMM_WB(11).
- IMM_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0. Retires; goes to FETCH.
- Retire: instr_count increments by 1 on the clk edge leaving a retiring state; it wraps from 2^CNT_W-1 to 0. An illegal opcode does not retire.
- Encodings 12-15 are unreachable; if entered, the FSM goes to FETCH next cycle with all strobes 0.
- Latency, zero wait states:
  - lw: 5 cycles
  - sw, R-type, addi, andi: 4 cycles
  - beq, j: 3 cycles
- Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_ready is ignored in all other states.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 and opcode=000000: state sequence 0,1,6,7,0. reg_write=1 only in state 7 with reg_dst=1. alu_op=10 in state 6. instr_count=1 after.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 1 cycle in MEM_READ: states 0,0,0,1,2,3,3,4,0. ir_write=1 only on the third FETCH cycle. Total 8 cycles; mem_to_reg=1 in state 4.
- andi (001100) then addi (001000): IMM_EXEC alu_op=11, then 00. alu_src_b=10 in both. instr_count +2.
- beq then j: BRANCH shows alu_op=01, pc_write_cond=1, pc_source=01. JUMP shows pc_write=1, pc_source=10. 3 cycles each.
- Opcode 111111: illegal_op pulses in DECODE, next state 0, instr_count unchanged, no reg_write or mem_write.
- rst_n=0 asserted in MEM_WRITE while mem_ready=0: next state 0, mem_write drops the same cycle. Separately, with CNT_W=4 and 16 back-to-back j instructions, instr_count wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences one instruction
// at a time, drives every datapath mux/strobe and counts retired instructions.
module multicycle_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             illegal_op,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXECUTE   = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      IMM_EXEC  = 4'd10,
      IMM_WB    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;

   state_t     cur_state;
   state_t     nxt_state;
   logic [5:0] op_q;
   logic       retire;

   assign state = cur_state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_state   <= FETCH;
         instr_count <= '0;
      end else begin
         cur_state <= nxt_state;
         if (retire)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

   // Opcode is captured once so later states never depend on the IR port.
   always_ff @(posedge clk) begin
      if (cur_state == DECODE)
         op_q <= opcode;
   end

   always_comb begin
      nxt_state     = FETCH;
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;

      case (cur_state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            nxt_state = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE:       nxt_state = EXECUTE;
               OP_LW, OP_SW:   nxt_state = MEM_ADDR;
               OP_BEQ:         nxt_state = BRANCH;
               OP_J:           nxt_state = JUMP;
               OP_ADDI, OP_ANDI: nxt_state = IMM_EXEC;
               default: begin
                  illegal_op = 1'b1;
                  nxt_state  = FETCH;
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            mem_read  = 1'b1;
            i_or_d    = 1'b1;
            nxt_state = mem_ready ? MEM_WB : MEM_READ;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
         end
         MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            retire    = mem_ready;
            nxt_state = mem_ready ? FETCH : MEM_WRITE;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            nxt_state = R_WB;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            retire        = 1'b1;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            retire    = 1'b1;
         end
         IMM_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
            nxt_state = IMM_WB;
         end
         IMM_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         default: nxt_state = FETCH;
      endcase

      // Reset overrides everything so an abandoned instruction performs no writes.
      if (!rst_n) begin
         retire        = 1'b0;
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         i_or_d        = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         mem_to_reg    = 1'b0;
         reg_dst       = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         alu_op        = 2'b00;
         pc_source     = 2'b00;
         illegal_op    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state/controls/count
// are queued per instruction and compared as the FSM walks through them.
module tb_multicycle_control;

   localparam int CNT_W = 4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [5:0]       opcode = '0;
   logic             mem_ready = 1'b0;
   logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic             mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0]       alu_src_b, alu_op, pc_source;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_count;

   multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]       st;
      logic             mr;
      logic [5:0]       opin;
      logic [5:0]       op;
      logic [CNT_W-1:0] cnt;
   } ent_t;

   ent_t             sb[$];
   int               errors = 0;
   int               checks = 0;
   logic [CNT_W-1:0] cnt_m = '0;
   logic [16:0]      ctrl_obs;

   assign ctrl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal_op};

   // Expected control word for a state, straight from the state-by-state output table.
   function automatic logic [16:0] ctrl_word(logic [3:0] st, logic [5:0] op, logic mr);
      logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, ill;
      logic [1:0] sbs, aop, psrc;
      {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, ill} = '0;
      {sbs, aop, psrc} = '0;
      case (st)
         4'd0:  begin mrd = 1'b1; sbs = 2'b01; irw = mr; pw = mr; end
         4'd1:  begin
            sbs = 2'b11;
            ill = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI});
         end
         4'd2:  begin sa = 1'b1; sbs = 2'b10; end
         4'd3:  begin mrd = 1'b1; iod = 1'b1; end
         4'd4:  begin rw = 1'b1; m2r = 1'b1; end
         4'd5:  begin mwr = 1'b1; iod = 1'b1; end
         4'd6:  begin sa = 1'b1; aop = 2'b10; end
         4'd7:  begin rw = 1'b1; rdst = 1'b1; end
         4'd8:  begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
         4'd9:  begin pw = 1'b1; psrc = 2'b10; end
         4'd10: begin sa = 1'b1; sbs = 2'b10; aop = (op == OP_ANDI) ? 2'b11 : 2'b00; end
         4'd11: begin rw = 1'b1; end
         default: ;
      endcase
      return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sbs, aop, psrc, ill};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op,
                       input logic [5:0] opin);
      ent_t e;
      e.st = st; e.mr = mr; e.op = op; e.opin = opin; e.cnt = cnt_m;
      sb.push_back(e);
   endtask

   // Drives each queued cycle, then compares at the falling edge.
   task automatic drain();
      ent_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         mem_ready = e.mr;
         opcode    = e.opin;
         @(negedge clk);
         chk($sformatf("state(exp %0d)", e.st), 32'(state), 32'(e.st));
         chk($sformatf("ctrl(st %0d)", e.st), 32'(ctrl_obs), 32'(ctrl_word(e.st, e.op, e.mr)));
         chk($sformatf("count(st %0d)", e.st), 32'(instr_count), 32'(e.cnt));
         @(posedge clk);
         #1;
      end
   endtask

   // Queues one instruction: fw FETCH wait cycles, mw memory wait cycles.
   task automatic instr(input logic [5:0] op, input int fw, input int mw);
      logic legal;
      legal = 1'b1;
      for (int i = 0; i < fw; i++) push(4'd0, 1'b0, op, OP_BAD);
      push(4'd0, 1'b1, op, OP_BAD);
      push(4'd1, 1'($urandom_range(0, 1)), op, op);
      case (op)
         OP_RTYPE: begin push(4'd6, 1'b0, op, OP_BAD); push(4'd7, 1'b1, op, OP_BAD); end
         OP_LW: begin
            push(4'd2, 1'b0, op, OP_BAD);
            for (int i = 0; i < mw; i++) push(4'd3, 1'b0, op, OP_BAD);
            push(4'd3, 1'b1, op, OP_BAD);
            push(4'd4, 1'b0, op, OP_BAD);
         end
         OP_SW: begin
            push(4'd2, 1'b1, op, OP_BAD);
            for (int i = 0; i < mw; i++) push(4'd5, 1'b0, op, OP_BAD);
            push(4'd5, 1'b1, op, OP_BAD);
         end
         OP_BEQ: push(4'd8, 1'b0, op, OP_BAD);
         OP_J:   push(4'd9, 1'b0, op, OP_BAD);
         OP_ADDI, OP_ANDI: begin push(4'd10, 1'b0, op, OP_BAD); push(4'd11, 1'b0, op, OP_BAD); end
         default: legal = 1'b0;
      endcase
      drain();
      if (legal) cnt_m = cnt_m + 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      opcode    = OP_RTYPE;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset state", 32'(state), 32'd0);
         chk("reset ctrl", 32'(ctrl_obs), 32'd0);
         chk("reset count", 32'(instr_count), 32'd0);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      cnt_m = '0;

      instr(OP_RTYPE, 0, 0);
      instr(OP_LW, 2, 1);
      instr(OP_ANDI, 0, 0);
      instr(OP_ADDI, 0, 0);
      instr(OP_BEQ, 0, 0);
      instr(OP_J, 0, 0);
      instr(OP_BAD, 0, 0);
      instr(OP_SW, 1, 2);
      instr(OP_RTYPE, 0, 0);

      // sw abandoned by reset while waiting on memory
      push(4'd0, 1'b1, OP_SW, OP_BAD);
      push(4'd1, 1'b1, OP_SW, OP_SW);
      push(4'd2, 1'b1, OP_SW, OP_BAD);
      drain();
      mem_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      chk("rst in MEM_WRITE state", 32'(state), 32'd5);
      chk("rst in MEM_WRITE ctrl", 32'(ctrl_obs), 32'd0);
      chk("rst in MEM_WRITE mem_write", 32'(mem_write), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("after rst state", 32'(state), 32'd0);
      chk("after rst count", 32'(instr_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cnt_m = '0;

      for (int i = 0; i < 16; i++) instr(OP_J, 0, 0);
      @(negedge clk);
      chk("count wrap", 32'(instr_count), 32'd0);
      @(posedge clk);
      #1;
      instr(OP_RTYPE, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
